// File: rtl/wolfram_ca_pkg.sv
// Shared definitions for the Wolfram elementary cellular-automaton engine.
//   RULE_W     : width of a Wolfram rule number (8 entries, one per neighbourhood)
//   ca_state_t : engine FSM state encoding
//   nbr_idx_t  : 3-bit neighbourhood index {left, self, right}
package wolfram_ca_pkg;

  localparam int RULE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ca_state_t;

  typedef logic [2:0] nbr_idx_t;

endpackage

// File: rtl/wolfram_ca_cell.sv
// Next-state lookup for a single cell (purely combinational).
//   rule : 8-bit Wolfram rule; bit n is the output for neighbourhood value n
//   nbr  : neighbourhood {left, self, right}
//   nxt  : next state of the cell
module wolfram_ca_cell
  import wolfram_ca_pkg::*;
(
  input  logic [RULE_W-1:0] rule,
  input  logic [2:0]        nbr,
  output logic              nxt
);

  nbr_idx_t idx;

  assign idx = nbr;
  assign nxt = rule[idx];

endmodule

// File: rtl/wolfram_ca_engine.sv
// Elementary cellular-automaton engine: loads a seed row, then applies one
// generation per clock in RUN until the requested generation count is reached.
//   clk, rst_n   : clock, asynchronous active-low reset
//   rule_i       : Wolfram rule number (latched at start)
//   seed_i       : initial row, bit WIDTH-1 is the leftmost cell
//   wrap_i       : 1 = periodic boundary, 0 = outside cells read 0 (latched)
//   gens_i       : generations to run (latched)
//   start_i      : run request, honoured only in IDLE
//   busy_o       : high while in RUN
//   done_o       : one-cycle completion pulse
//   cells_o      : current row
//   gen_cnt_o    : generations applied in the current/last run
//   stable_o     : fixed point reached (only with WOLFRAM_CA_STABLE_EN)
// Build option: define WOLFRAM_CA_STABLE_EN to stop early when the next row
// equals the current row.
module wolfram_ca_engine
  import wolfram_ca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RULE_W-1:0] rule_i,
  input  logic [WIDTH-1:0]  seed_i,
  input  logic              wrap_i,
  input  logic [GEN_W-1:0]  gens_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [WIDTH-1:0]  cells_o,
  output logic [GEN_W-1:0]  gen_cnt_o
`ifdef WOLFRAM_CA_STABLE_EN
  ,
  output logic              stable_o
`endif
);

  ca_state_t         state;
  logic [RULE_W-1:0] rule_q;
  logic              wrap_q;
  logic [GEN_W-1:0]  gens_q;
  logic [WIDTH-1:0]  cells;
  logic [WIDTH-1:0]  nxt_row;
  logic [GEN_W-1:0]  gen_cnt;
  logic [GEN_W-1:0]  gen_inc;

  assign gen_inc = gen_cnt + GEN_W'(1);

  // Edge cells take their missing neighbour from the opposite end when
  // wrapping, otherwise a constant 0.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic left, right;
    if (i == WIDTH - 1) begin : g_lmsb
      assign left = wrap_q & cells[0];
    end else begin : g_lin
      assign left = cells[i+1];
    end
    if (i == 0) begin : g_rlsb
      assign right = wrap_q & cells[WIDTH-1];
    end else begin : g_rin
      assign right = cells[i-1];
    end
    wolfram_ca_cell u_cell (
      .rule (rule_q),
      .nbr  ({left, cells[i], right}),
      .nxt  (nxt_row[i])
    );
  end

`ifdef WOLFRAM_CA_STABLE_EN
  logic stable;
  assign stable_o = stable;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cells   <= '0;
      gen_cnt <= '0;
      rule_q  <= '0;
      wrap_q  <= 1'b0;
      gens_q  <= '0;
`ifdef WOLFRAM_CA_STABLE_EN
      stable  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            cells   <= seed_i;
            gen_cnt <= '0;
            rule_q  <= rule_i;
            wrap_q  <= wrap_i;
            gens_q  <= gens_i;
`ifdef WOLFRAM_CA_STABLE_EN
            stable  <= 1'b0;
`endif
            state   <= (gens_i == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
`ifdef WOLFRAM_CA_STABLE_EN
          // Fixed point: leave the row and count untouched and finish now.
          if (nxt_row == cells) begin
            stable <= 1'b1;
            state  <= ST_DONE;
          end else
`endif
          begin
            cells   <= nxt_row;
            gen_cnt <= gen_inc;
            if (gen_inc == gens_q) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o    = (state == ST_RUN);
  assign done_o    = (state == ST_DONE);
  assign cells_o   = cells;
  assign gen_cnt_o = gen_cnt;

endmodule

// File: tb/tb_wolfram_ca_engine.sv
// Scoreboard bench for wolfram_ca_engine (WIDTH=8). Each launched run pushes
// its expected result (row, count, done cycle, busy length, stable flag); the
// monitor pops and compares on every done_o pulse.
module tb_wolfram_ca_engine;

  localparam int W  = 8;
  localparam int GW = 8;

  logic          clk;
  logic          rst_n;
  logic [7:0]    rule_i;
  logic [W-1:0]  seed_i;
  logic          wrap_i;
  logic [GW-1:0] gens_i;
  logic          start_i;
  logic          busy_o;
  logic          done_o;
  logic [W-1:0]  cells_o;
  logic [GW-1:0] gen_cnt_o;
`ifdef WOLFRAM_CA_STABLE_EN
  logic          stable_o;
`endif

  wolfram_ca_engine #(.WIDTH(W), .GEN_W(GW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rule_i    (rule_i),
    .seed_i    (seed_i),
    .wrap_i    (wrap_i),
    .gens_i    (gens_i),
    .start_i   (start_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .cells_o   (cells_o),
    .gen_cnt_o (gen_cnt_o)
`ifdef WOLFRAM_CA_STABLE_EN
    ,
    .stable_o  (stable_o)
`endif
  );

  typedef struct {
    logic [W-1:0]  cells;
    logic [GW-1:0] gen;
    int            done_cyc;
    int            busy;
    logic          stable;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   done_total = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference step: l[i] = c[i+1], r[i] = c[i-1], built by shifting the row.
  function automatic logic [W-1:0] ca_step(input logic [W-1:0] row,
                                           input logic [7:0] rule, input logic wrap);
    logic [W-1:0] l, r, n;
    logic [7:0]   rv;
    rv = rule;
    l  = {wrap & row[0], row[W-1:1]};
    r  = {row[W-2:0], wrap & row[W-1]};
    for (int i = 0; i < W; i++) n[i] = rv[{l[i], row[i], r[i]}];
    return n;
  endfunction

  // Monitor: busy length and done pulses, checked at the falling edge.
  initial begin
    int busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
      end else begin
        if (busy_o) busy_cnt++;
        if (done_o) begin
          done_total++;
          chk("done_busy_excl", 64'(busy_o), 64'(0));
          if (sb.size() == 0) begin
            chk("spurious_done", 64'(done_o), 64'(0));
          end else begin
            e = sb.pop_front();
            chk("cells", 64'(cells_o), 64'(e.cells));
            chk("gen_cnt", 64'(gen_cnt_o), 64'(e.gen));
            chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
            chk("busy_len", 64'(busy_cnt), 64'(e.busy));
`ifdef WOLFRAM_CA_STABLE_EN
            chk("stable", 64'(stable_o), 64'(e.stable));
`endif
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic run_ca(input logic [7:0] rule, input logic [W-1:0] seed,
                        input logic wrap, input logic [GW-1:0] gens);
    exp_t         e;
    logic [W-1:0] row, nx;
    int           cnt;
    logic         st;
    row = seed; cnt = 0; st = 1'b0;
    for (int g = 0; g < int'(gens); g++) begin
      nx = ca_step(row, rule, wrap);
`ifdef WOLFRAM_CA_STABLE_EN
      if (nx == row) begin st = 1'b1; break; end
`endif
      row = nx;
      cnt++;
    end
    @(negedge clk);
    rule_i = rule; seed_i = seed; wrap_i = wrap; gens_i = gens; start_i = 1'b1;
    e.cells    = row;
    e.gen      = GW'(cnt);
    e.stable   = st;
    e.busy     = st ? cnt + 1 : cnt;
    e.done_cyc = cyc + (st ? cnt + 2 : cnt + 1);
    sb.push_back(e);
    @(negedge clk);
    // Launch inputs must not matter once the run is under way.
    start_i = 1'b0;
    rule_i = 8'($urandom); seed_i = W'($urandom); wrap_i = 1'($urandom);
    gens_i = GW'($urandom);
    if (gens != '0) begin
      // Lands while the engine is in RUN or DONE: must be ignored.
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    for (int t = 0; t < 400 && sb.size() != 0; t++) @(negedge clk);
    chk("timeout", 64'(sb.size()), 64'(0));
    repeat (3) @(negedge clk);
    seed_i = ~seed_i;
    @(negedge clk);
    chk("hold_cells", 64'(cells_o), 64'(e.cells));
    chk("hold_gen", 64'(gen_cnt_o), 64'(e.gen));
  endtask

  initial begin
    int dt;
    rst_n = 1'b0; start_i = 1'b0; rule_i = '0; seed_i = '0; wrap_i = 1'b0; gens_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_cells", 64'(cells_o), 64'(0));
    chk("rst_gen", 64'(gen_cnt_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
`ifdef WOLFRAM_CA_STABLE_EN
    chk("rst_stable", 64'(stable_o), 64'(0));
`endif
    rst_n = 1'b1;

    run_ca(8'h5A, 8'b0001_0000, 1'b0, 8'd1);
    run_ca(8'hAA, 8'h80, 1'b1, 8'd1);
    run_ca(8'hAA, 8'h80, 1'b0, 8'd1);
    run_ca(8'h81, 8'h00, 1'b1, 8'd10);
    run_ca(8'h5A, 8'h3C, 1'b1, 8'd0);
    run_ca(8'd30, 8'h01, 1'b1, 8'd12);
    for (int n = 0; n < 6; n++)
      run_ca(8'($urandom), W'($urandom), 1'($urandom), GW'($urandom_range(0, 20)));

    // Reset in the middle of a 10-generation run.
    @(negedge clk);
    rule_i = 8'd30; seed_i = 8'h01; wrap_i = 1'b1; gens_i = 8'd10; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int t = 0; t < 20 && gen_cnt_o != 8'd3; t++) @(negedge clk);
    chk("reach_gen3", 64'(gen_cnt_o), 64'(3));
    dt = done_total;
    rst_n = 1'b0;
    #1;
    chk("midrst_cells", 64'(cells_o), 64'(0));
    chk("midrst_gen", 64'(gen_cnt_o), 64'(0));
    chk("midrst_busy", 64'(busy_o), 64'(0));
    chk("midrst_done", 64'(done_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("no_done_after_rst", 64'(done_total), 64'(dt));
    chk("idle_after_rst", 64'(busy_o), 64'(0));

    // Engine must be usable again after the aborted run.
    run_ca(8'h5A, 8'b0001_0000, 1'b0, 8'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/wolfram_ca_engine.md
WOLFRAM_CA_ENGINE -- requirements
Module: wolfram_ca_engine

Interface
REQ-001 Parameter WIDTH, default 16: number of cells; legal range 3..64.
REQ-002 Parameter GEN_W, default 8: width of the generation count.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port rule_i, input, 8: Wolfram rule number.
REQ-006 Port seed_i, input, WIDTH: initial cell row; bit WIDTH-1 is the leftmost cell.
REQ-007 Port wrap_i, input, 1: boundary mode; 1 = periodic, 0 = null (outside cells read 0).
REQ-008 Port gens_i, input, GEN_W: number of generations to run.
REQ-009 Port start_i, input, 1: run request.
REQ-010 Port busy_o, output, 1: high while in RUN.
REQ-011 Port done_o, output, 1: one-cycle completion pulse.
REQ-012 Port cells_o, output, WIDTH: current cell row (registered).
REQ-013 Port gen_cnt_o, output, GEN_W: generations applied in the current or last run.
REQ-014 Port stable_o, output, 1: present only with WOLFRAM_CA_STABLE_EN (REQ-030).

Function
REQ-015 FSM states: IDLE, RUN and DONE.
- IDLE: sampling start_i=1 loads cells<=seed_i, gen_cnt<=0, and latches rule_i, wrap_i and gens_i.
- Next state after start is RUN, or DONE when gens_i==0.
REQ-016 Each cycle in RUN applies one generation to all cells in parallel and increments gen_cnt.
REQ-017 Neighbourhood index for cell i is {c[i+1], c[i], c[i-1]} (left, self, right); new c[i] = rule[index].
REQ-018 Boundaries:
- wrap=1: c[WIDTH] is read as c[0], and c[-1] is read as c[WIDTH-1].
- wrap=0: both read as 0.
REQ-019 Termination: on the edge where gen_cnt becomes the latched gens, the FSM moves RUN->DONE.
REQ-020 Latency: start sampled on edge k; updates occur on edges k+1..k+gens; done_o is high for the single cycle after edge k+gens.
REQ-021 DONE lasts exactly one cycle: done_o=1, busy_o=0, then the FSM returns to IDLE.
REQ-022 start_i is ignored in RUN and DONE; it is not queued.
REQ-023 Changes to rule_i, wrap_i, gens_i or seed_i after launch do not affect the run in progress.
REQ-024 cells_o and gen_cnt_o hold their values in IDLE until the next accepted start.

Reset
REQ-025 Asserting rst_n low, including mid-run, immediately forces:
- state IDLE;
- cells_o=0, gen_cnt_o=0;
- busy_o=0, done_o=0, stable_o=0;
- latched rule=0, wrap=0, gens=0.
REQ-026 The first accepted start is the first start_i=1 sampled at a rising edge after rst_n deasserts.

Configuration
REQ-027 Macro WOLFRAM_CA_STABLE_EN controls early-stop on a fixed point.
REQ-028 With WOLFRAM_CA_STABLE_EN defined, when the computed next row equals the current row in RUN:
- the update is not applied;
- gen_cnt does not increment;
- the FSM enters DONE with stable_o=1.
REQ-029 stable_o holds until the next accepted start or reset.
REQ-030 Without WOLFRAM_CA_STABLE_EN, the stable_o port and the comparison logic are absent, and every run executes exactly gens generations.

Structure
REQ-031 Package wolfram_ca_pkg holds the FSM state enum, the RULE_W=8 constant and the neighbourhood index type.
REQ-032 Sub-module wolfram_ca_cell computes one cell's next state from the 8-bit rule and the 3-bit neighbourhood (combinational); it is instantiated WIDTH times via generate.

Verification
REQ-033 Rule 90:
- Stimulus: WIDTH=8, rule 8'h5A, seed 8'b0001_0000, wrap=0, gens=1.
- Response: cells_o=8'b0010_1000, gen_cnt_o=1, done_o pulses exactly 2 cycles after start.
REQ-034 Rule 170, periodic boundary:
- Stimulus: rule 8'hAA, seed 8'h80, wrap=1, gens=1.
- Response: cells_o=8'h01.
REQ-035 Rule 170, null boundary:
- Stimulus: as REQ-034 but wrap=0.
- Response: cells_o=8'h00.
REQ-036 Rule 129 (8'h81), seed 8'h00, wrap=1, gens=10:
- Without WOLFRAM_CA_STABLE_EN: cells_o=8'hFF, gen_cnt_o=10, busy for 10 cycles.
- With WOLFRAM_CA_STABLE_EN: cells_o=8'hFF, gen_cnt_o=1, stable_o=1, done_o on the third cycle after start.
REQ-037 gens=0:
- Response: done_o the cycle after start, busy_o never high, cells_o=seed, gen_cnt_o=0.
REQ-038 Start during a run, then reset mid-run:
- A second start pulse while busy_o=1 is ignored, and the run ends at the original gens count.
- rst_n low at gen 3 of 10 clears cells_o and gen_cnt_o at once, and no done_o follows.
